// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN layer dimensions and the pooling FSM state type
package cnn_pkg;
  localparam int DATA_SIZE = 64;
  localparam int NUM_CH = 16;
  localparam int IN_DIM = 26;
  localparam int POOL_DIM = 2;
  typedef enum logic [2:0] {IDLE, READ, CMP, WRITE, FIN} pool_state_t;
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: window counters (c, oy, ox, in-window ky/kx) and flat read/write address arithmetic
module pool_addr_gen #(
  parameter int NUM_CH = cnn_pkg::NUM_CH,
  parameter int IN_DIM = cnn_pkg::IN_DIM,
  parameter int POOL_DIM = cnn_pkg::POOL_DIM
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_step,
  input  logic        win_step,
  output logic        last_k,
  output logic        last_win,
  output logic [15:0] rd_addr,
  output logic [15:0] wr_addr
);
  import cnn_pkg::*;
  localparam int OUT_DIM = IN_DIM / POOL_DIM;
  logic [15:0] kx, ky, ox, oy, c;
  logic lx, lox, loy;
  assign lx = kx == 16'(POOL_DIM - 1);
  assign last_k = lx && ky == 16'(POOL_DIM - 1);
  assign lox = ox == 16'(OUT_DIM - 1);
  assign loy = oy == 16'(OUT_DIM - 1);
  assign last_win = lox && loy && c == 16'(NUM_CH - 1);
  // all counters wrap to zero after the final window, so no explicit clear is needed
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
      c  <= '0;
    end else begin
      if (rd_step) begin
        kx <= lx ? '0 : kx + 1'b1;
        ky <= last_k ? '0 : lx ? ky + 1'b1 : ky;
      end
      if (win_step) begin
        ox <= lox ? '0 : ox + 1'b1;
        oy <= lox ? (loy ? '0 : oy + 1'b1) : oy;
        c  <= lox && loy ? (last_win ? '0 : c + 1'b1) : c;
      end
    end
  assign rd_addr = c * 16'(IN_DIM * IN_DIM) + (oy * 16'(POOL_DIM) + ky) * 16'(IN_DIM)
                 + ox * 16'(POOL_DIM) + kx;
  assign wr_addr = c * 16'(OUT_DIM * OUT_DIM) + oy * 16'(OUT_DIM) + ox;
endmodule

// File: rtl/l2_maxpool.sv
// l2_maxpool: signed max-pooling engine over a flat CHW input memory.
// Define L2_MAXPOOL_RELU_EN to clamp the written maximum at zero (fused ReLU).
module l2_maxpool #(
  parameter int DATA_SIZE = cnn_pkg::DATA_SIZE,
  parameter int NUM_CH = cnn_pkg::NUM_CH,
  parameter int IN_DIM = cnn_pkg::IN_DIM,
  parameter int POOL_DIM = cnn_pkg::POOL_DIM
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_en,
  output logic [15:0]                 rd_addr,
  input  logic signed [DATA_SIZE-1:0] rd_data,
  output logic                        wr_en,
  output logic [15:0]                 wr_addr,
  output logic [DATA_SIZE-1:0]        wr_data
);
  import cnn_pkg::*;
  pool_state_t state, state_nx;
  logic last_k, last_win, vld, first;
  logic signed [DATA_SIZE-1:0] acc;
  pool_addr_gen #(.NUM_CH(NUM_CH), .IN_DIM(IN_DIM), .POOL_DIM(POOL_DIM)) u_addr (
    .clk(clk),
    .reset(reset),
    .rd_step(rd_en),
    .win_step(wr_en),
    .last_k(last_k),
    .last_win(last_win),
    .rd_addr(rd_addr),
    .wr_addr(wr_addr)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (start ? READ : IDLE)
             : state == READ  ? (last_k ? CMP : READ)
             : state == CMP   ? WRITE
             : state == WRITE ? (last_win ? FIN : READ)
             : IDLE;
  end
  assign rd_en = state == READ;
  assign wr_en = state == WRITE;
  assign done = state == FIN;
  assign busy = rd_en || wr_en || state == CMP;
  // vld/first track the read issued last cycle; first marks the opening read of a window
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      vld   <= 1'b0;
      first <= 1'b0;
      acc   <= '0;
    end else begin
      vld   <= rd_en;
      first <= rd_en && !vld;
      if (vld) acc <= first || rd_data > acc ? rd_data : acc;
    end
`ifdef L2_MAXPOOL_RELU_EN
  assign wr_data = acc[DATA_SIZE-1] ? '0 : acc;
`else
  assign wr_data = acc;
`endif
endmodule

// File: tb/tb_l2_maxpool.sv
// tb_l2_maxpool: directed checks of l2_maxpool (default 16x26x26 map, plus a 1x27x27 odd-size instance)
module tb_l2_maxpool;
  logic clk, reset, start, start27;
  logic busy, done, rd_en, wr_en;
  logic [15:0] rd_addr, wr_addr;
  logic [63:0] rd_data, wr_data;
  logic busy27, done27, rd27_en, wr27_en;
  logic [15:0] rd27_addr, wr27_addr;
  logic [63:0] rd27_data, wr27_data;
  bit mode;
  int checks, errors;
  int rd_n, rd_bad, wr_n, wr_bad, done_n;
  int rd27_n, bad27, wr27_n, done27_n;
  longint first_wa, first_wd, last_wa, last_wd, last27_wa, last27_wd;
  int n;

  l2_maxpool u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  l2_maxpool #(.NUM_CH(1), .IN_DIM(27)) u_odd (
    .clk(clk), .reset(reset), .start(start27), .busy(busy27), .done(done27),
    .rd_en(rd27_en), .rd_addr(rd27_addr), .rd_data(rd27_data),
    .wr_en(wr27_en), .wr_addr(wr27_addr), .wr_data(wr27_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint mem(input int a, input bit m);
    if (m && a == 0) return -5;
    if (m && a == 1) return -3;
    if (m && a == 26) return -9;
    if (m && a == 27) return -3;
    return longint'(a);
  endfunction

  always @(posedge clk) begin
    rd_data <= 64'(mem(int'(rd_addr), mode));
    rd27_data <= 64'(rd27_addr);
  end

  always @(negedge clk) if (reset) begin
    int w, k, c, oy, ox;
    if (rd_en) begin
      w = rd_n / 4; k = rd_n % 4; c = w / 169; oy = (w / 13) % 13; ox = w % 13;
      if (rd_addr != 16'(c * 676 + (2 * oy + k / 2) * 26 + 2 * ox + k % 2)) rd_bad++;
      rd_n++;
    end
    if (wr_en) begin
      w = wr_n; c = w / 169; oy = (w / 13) % 13; ox = w % 13;
      if (wr_addr != 16'(w)) wr_bad++;
      if (!(mode && w == 0) && wr_data != 64'(c * 676 + (2 * oy + 1) * 26 + 2 * ox + 1)) wr_bad++;
      if (wr_n == 0) begin first_wa = longint'(wr_addr); first_wd = $signed(wr_data); end
      last_wa = longint'(wr_addr);
      last_wd = $signed(wr_data);
      wr_n++;
    end
    if (done) done_n++;
    if (rd27_en) begin
      if (rd27_addr % 27 == 26 || rd27_addr / 27 >= 26) bad27++;
      rd27_n++;
    end
    if (wr27_en) begin
      wr27_n++;
      last27_wa = longint'(wr27_addr);
      last27_wd = $signed(wr27_data);
    end
    if (done27) done27_n++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon();
    rd_n = 0; rd_bad = 0; wr_n = 0; wr_bad = 0; done_n = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_rd_en"}, longint'(rd_en), 0);
    check({tag, "_wr_en"}, longint'(wr_en), 0);
    check({tag, "_rd_addr"}, longint'(rd_addr), 0);
    check({tag, "_wr_addr"}, longint'(wr_addr), 0);
    check({tag, "_wr_data"}, longint'(wr_data), 0);
  endtask

  initial begin
    longint exp_neg;
    checks = 0; errors = 0; mode = 0;
    rd27_n = 0; bad27 = 0; wr27_n = 0; done27_n = 0;
    reset = 1'b0; start = 1'b0; start27 = 1'b0;
    clr_mon();
    repeat (3) step();
    check_zero("rst");
    reset = 1'b1;
    step();
    // full run on input[a] = a
    start = 1'b1; step(); start = 1'b0; n = 1;
    check("busy_after_start", longint'(busy), 1);
    check("rd_en_after_start", longint'(rd_en), 1);
    while (!done && n < 20000) begin step(); n++; end
    check("done_cycle", n, 16225);
    step();
    check("done_one_cycle", longint'(done), 0);
    check("wr_count", wr_n, 2704);
    check("rd_count", rd_n, 10816);
    check("rd_seq_bad", rd_bad, 0);
    check("wr_seq_bad", wr_bad, 0);
    check("first_wr_addr", first_wa, 0);
    check("first_wr_data", first_wd, 27);
    check("last_wr_addr", last_wa, 2703);
    check("last_wr_data", last_wd, 10815);
    check("done_count", done_n, 1);
    // negative window, then abort by reset inside window 100
    mode = 1; clr_mon();
    start = 1'b1; step(); start = 1'b0; n = 0;
    while (!wr_en && n < 100) begin step(); n++; end
`ifdef L2_MAXPOOL_RELU_EN
    exp_neg = 0;
`else
    exp_neg = -3;
`endif
    check("neg_win_data", $signed(wr_data), exp_neg);
    check("neg_win_addr", longint'(wr_addr), 0);
    while (wr_n < 100 && n < 2000) begin step(); n++; end
    step(); step();
    check("mid_rd_en", longint'(rd_en), 1);
    reset = 1'b0;
    #1;
    check_zero("abort");
    repeat (3) step();
    check("abort_no_done", done_n, 0);
    check("abort_busy", longint'(busy), 0);
    // restart right at reset release, with start re-pulsed mid-run and in FIN
    mode = 0; clr_mon();
    reset = 1'b1; start = 1'b1; step(); start = 1'b0; n = 1;
    check("busy_after_reset", longint'(busy), 1);
    while (!done && n < 20000) begin
      start = n == 50 || n == 8000;
      step();
      n++;
    end
    check("done_cycle_restart", n, 16225);
    start = 1'b1; step(); start = 1'b0;
    check("fin_start_ignored", longint'(busy), 0);
    repeat (3) step();
    check("restart_wr_count", wr_n, 2704);
    check("restart_done_count", done_n, 1);
    check("restart_wr_seq_bad", wr_bad, 0);
    check("restart_rd_seq_bad", rd_bad, 0);
    // odd input side: trailing row/column skipped
    start27 = 1'b1; step(); start27 = 1'b0; n = 1;
    while (!done27 && n < 5000) begin step(); n++; end
    check("odd_done_cycle", n, 1015);
    step();
    check("odd_wr_count", wr27_n, 169);
    check("odd_rd_count", rd27_n, 676);
    check("odd_edge_reads", bad27, 0);
    check("odd_last_wr_addr", last27_wa, 168);
    check("odd_last_wr_data", last27_wd, 700);
    check("odd_done_count", done27_n, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
